alu_operand_stage: RTL and testbench

ID/EX pipeline stage that sits directly upstream of the ALU in the pipelined CPU. It registers decoded instruction fields from ID and resolves operand forwarding from the EX/MEM and MEM/WB stages. It drives the ALU inputs A, B, ALUFun and Sign, plus the control that travels downstream. It also detects load-use hazards and inserts bubbles on stall or branch flush.

---
 rtl/cpu_pipe_pkg.sv | 38 +++
 rtl/fwd_unit.sv | 43 ++++
 rtl/alu_operand_stage.sv | 115 +++++++++++
 tb/tb_alu_operand_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared pipeline widths, ALU function codes, ALU groups and forward selects
package cpu_pipe_pkg;
    localparam int DATA_W = 32;
    localparam int RADDR_W = 5;
    // ALU_ADD doubles as the bubble function code
    typedef enum logic [5:0] {
        ALU_ADD = 6'b000000,
        ALU_SUB = 6'b000001,
        ALU_AND = 6'b011000,
        ALU_OR  = 6'b011110,
        ALU_XOR = 6'b010110,
        ALU_NOR = 6'b010001,
        ALU_A   = 6'b011010,
        ALU_SLL = 6'b100000,
        ALU_SRL = 6'b100001,
        ALU_SRA = 6'b100011,
        ALU_EQ  = 6'b110011,
        ALU_NEQ = 6'b110001,
        ALU_LT  = 6'b110101,
        ALU_LEZ = 6'b111101,
        ALU_LTZ = 6'b111011,
        ALU_GTZ = 6'b111111
    } alufun_e;
    typedef enum logic [1:0] {
        GRP_ADDSUB = 2'b00,
        GRP_LOGIC  = 2'b01,
        GRP_SHIFT  = 2'b10,
        GRP_CMP    = 2'b11
    } alu_grp_e;
    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;
    function automatic alu_grp_e alu_group(input logic [5:0] fun);
        return alu_grp_e'(fun[5:4]);
    endfunction
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: rs/rt forward selects for the EX operands and the load-use stall.
// FORWARDING_EN undefined: selects fixed to register data, stall on any RAW against EX or EX/MEM.
module fwd_unit
    import cpu_pipe_pkg::*;
(
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs_addr,
    input  logic [RADDR_W-1:0] id_rt_addr,
    input  logic               ex_valid,
    input  logic               ex_regwrite,
    input  logic               ex_memread,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic [RADDR_W-1:0] ex_rs_addr,
    input  logic [RADDR_W-1:0] ex_rt_addr,
    input  logic               exmem_regwrite,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic               memwb_regwrite,
    input  logic [RADDR_W-1:0] memwb_rd,
    output logic [1:0]         fwd_rs_sel,
    output logic [1:0]         fwd_rt_sel,
    output logic               ld_stall
);
`ifdef FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif
    logic exm_rs, exm_rt, mwb_rs, mwb_rt, raw_rs, raw_rt, load_use;
    assign exm_rs = exmem_regwrite && exmem_rd != '0 && exmem_rd == ex_rs_addr;
    assign exm_rt = exmem_regwrite && exmem_rd != '0 && exmem_rd == ex_rt_addr;
    assign mwb_rs = memwb_regwrite && memwb_rd != '0 && memwb_rd == ex_rs_addr;
    assign mwb_rt = memwb_regwrite && memwb_rd != '0 && memwb_rd == ex_rt_addr;
    assign fwd_rs_sel = !FWD_EN ? FWD_REG : exm_rs ? FWD_EXMEM : mwb_rs ? FWD_MEMWB : FWD_REG;
    assign fwd_rt_sel = !FWD_EN ? FWD_REG : exm_rt ? FWD_EXMEM : mwb_rt ? FWD_MEMWB : FWD_REG;
    // without forwarding, a producer in EX or EX/MEM must drain before ID may read
    assign raw_rs = id_rs_addr != '0 && ((ex_valid && ex_regwrite && ex_rd == id_rs_addr) ||
                                         (exmem_regwrite && exmem_rd == id_rs_addr));
    assign raw_rt = id_rt_addr != '0 && ((ex_valid && ex_regwrite && ex_rd == id_rt_addr) ||
                                         (exmem_regwrite && exmem_rd == id_rt_addr));
    assign load_use = ex_valid && ex_memread && ex_rd != '0 && id_valid &&
                      (ex_rd == id_rs_addr || ex_rd == id_rt_addr);
    assign ld_stall = load_use || (!FWD_EN && id_valid && (raw_rs || raw_rt));
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX register with operand forwarding and hazard bubbles ahead of the ALU.
// Build option FORWARDING_EN enables EX/MEM and MEM/WB forwarding (see fwd_unit).
module alu_operand_stage
    import cpu_pipe_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm32,
    input  logic [4:0]         id_shamt,
    input  logic [RADDR_W-1:0] id_rs_addr,
    input  logic [RADDR_W-1:0] id_rt_addr,
    input  logic [RADDR_W-1:0] id_rd_addr,
    input  logic [5:0]         id_alufun,
    input  logic               id_sign,
    input  logic               id_alusrc1,
    input  logic               id_alusrc2,
    input  logic               id_regwrite,
    input  logic               id_memread,
    input  logic               id_memwrite,
    input  logic               flush,
    input  logic               exmem_regwrite,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]  exmem_result,
    input  logic               memwb_regwrite,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]  memwb_result,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [5:0]         alu_fun,
    output logic               alu_sign,
    output logic [DATA_W-1:0]  ex_store_data,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_valid,
    output logic               ex_regwrite,
    output logic               ex_memread,
    output logic               ex_memwrite,
    output logic               ld_stall
);
    logic [DATA_W-1:0]  rs_data_q, rt_data_q, imm_q, fwd_rs, fwd_rt;
    logic [4:0]         shamt_q;
    logic [RADDR_W-1:0] rs_addr_q, rt_addr_q;
    logic               alusrc1_q, alusrc2_q;
    logic [1:0]         rs_sel, rt_sel;

    fwd_unit u_fwd (
        .id_valid      (id_valid),
        .id_rs_addr    (id_rs_addr),
        .id_rt_addr    (id_rt_addr),
        .ex_valid      (ex_valid),
        .ex_regwrite   (ex_regwrite),
        .ex_memread    (ex_memread),
        .ex_rd         (ex_rd),
        .ex_rs_addr    (rs_addr_q),
        .ex_rt_addr    (rt_addr_q),
        .exmem_regwrite(exmem_regwrite),
        .exmem_rd      (exmem_rd),
        .memwb_regwrite(memwb_regwrite),
        .memwb_rd      (memwb_rd),
        .fwd_rs_sel    (rs_sel),
        .fwd_rt_sel    (rt_sel),
        .ld_stall      (ld_stall)
    );

    // a bubble clears only the control bits; operand fields keep their old contents
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            alu_fun     <= ALU_ADD;
            alu_sign    <= 1'b0;
            ex_rd       <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            shamt_q     <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            alusrc1_q   <= 1'b0;
            alusrc2_q   <= 1'b0;
        end else if (flush || ld_stall) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            alu_fun     <= ALU_ADD;
        end else begin
            ex_valid    <= id_valid;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            ex_memwrite <= id_memwrite;
            alu_fun     <= id_alufun;
            alu_sign    <= id_sign;
            ex_rd       <= id_rd_addr;
            rs_data_q   <= id_rs_data;
            rt_data_q   <= id_rt_data;
            imm_q       <= id_imm32;
            shamt_q     <= id_shamt;
            rs_addr_q   <= id_rs_addr;
            rt_addr_q   <= id_rt_addr;
            alusrc1_q   <= id_alusrc1;
            alusrc2_q   <= id_alusrc2;
        end
    end

    assign fwd_rs = rs_sel == FWD_EXMEM ? exmem_result : rs_sel == FWD_MEMWB ? memwb_result : rs_data_q;
    assign fwd_rt = rt_sel == FWD_EXMEM ? exmem_result : rt_sel == FWD_MEMWB ? memwb_result : rt_data_q;
    assign alu_a = alusrc1_q ? {{(DATA_W-5){1'b0}}, shamt_q} : fwd_rs;
    assign alu_b = alusrc2_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed scenarios plus randomized traffic against an instruction-level model.
module tb_alu_operand_stage;
    import cpu_pipe_pkg::*;
`ifdef FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif
    logic clk, reset;
    logic id_valid, id_sign, id_alusrc1, id_alusrc2, id_regwrite, id_memread, id_memwrite, flush;
    logic [31:0] id_rs_data, id_rt_data, id_imm32, exmem_result, memwb_result;
    logic [4:0] id_shamt, id_rs_addr, id_rt_addr, id_rd_addr, exmem_rd, memwb_rd;
    logic [5:0] id_alufun;
    logic exmem_regwrite, memwb_regwrite;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [5:0] alu_fun;
    logic [4:0] ex_rd;
    logic alu_sign, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ld_stall;

    alu_operand_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm32(id_imm32), .id_shamt(id_shamt), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rd_addr(id_rd_addr), .id_alufun(id_alufun), .id_sign(id_sign), .id_alusrc1(id_alusrc1),
        .id_alusrc2(id_alusrc2), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .flush(flush), .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
        .memwb_result(memwb_result), .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ld_stall(ld_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // the instruction currently sitting in EX, as the model sees it
    typedef struct packed {
        logic valid;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0] shamt, rs, rt, rd;
        logic [5:0] fun;
        logic sign, src1, src2, regwrite, memread, memwrite;
    } ex_t;
    ex_t m;
    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_fwd(input logic [4:0] a, input logic [31:0] d);
        if (!FWD_EN || a == 0) return d;
        if (exmem_regwrite && exmem_rd == a) return exmem_result;
        if (memwb_regwrite && memwb_rd == a) return memwb_result;
        return d;
    endfunction

    function automatic logic raw_hit(input logic [4:0] a);
        return a != 0 && ((m.valid && m.regwrite && m.rd == a) || (exmem_regwrite && exmem_rd == a));
    endfunction

    function automatic logic exp_stall();
        logic lu;
        lu = m.valid && m.memread && m.rd != 0 && id_valid && (m.rd == id_rs_addr || m.rd == id_rt_addr);
        if (FWD_EN) return lu;
        return lu || (id_valid && (raw_hit(id_rs_addr) || raw_hit(id_rt_addr)));
    endfunction

    task automatic model_update();
        ex_t n;
        n = m;
        if (!reset) n = '0;
        else if (flush || exp_stall()) begin
            n.valid = 0; n.regwrite = 0; n.memread = 0; n.memwrite = 0; n.fun = 6'd0;
        end else begin
            n.valid = id_valid; n.rs_data = id_rs_data; n.rt_data = id_rt_data; n.imm = id_imm32;
            n.shamt = id_shamt; n.rs = id_rs_addr; n.rt = id_rt_addr; n.rd = id_rd_addr;
            n.fun = id_alufun; n.sign = id_sign; n.src1 = id_alusrc1; n.src2 = id_alusrc2;
            n.regwrite = id_regwrite; n.memread = id_memread; n.memwrite = id_memwrite;
        end
        m = n;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm32 = 0; id_shamt = 0;
        id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0; id_alufun = ALU_ADD; id_sign = 0;
        id_alusrc1 = 0; id_alusrc2 = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0; flush = 0;
        exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic rand_inputs();
        id_valid = $urandom_range(0, 3) != 0; id_rs_data = $urandom; id_rt_data = $urandom;
        id_imm32 = $urandom; id_shamt = 5'($urandom);
        id_rs_addr = 5'($urandom_range(0, 7)); id_rt_addr = 5'($urandom_range(0, 7));
        id_rd_addr = 5'($urandom_range(0, 7)); id_alufun = 6'($urandom); id_sign = 1'($urandom);
        id_alusrc1 = $urandom_range(0, 3) == 0; id_alusrc2 = $urandom_range(0, 2) == 0;
        id_regwrite = 1'($urandom); id_memread = $urandom_range(0, 2) == 0; id_memwrite = 1'($urandom);
        flush = $urandom_range(0, 7) == 0;
        exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
        memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
    endtask

    task automatic compare_all();
        check("ld_stall", 32'(ld_stall), 32'(exp_stall()));
        check("ex_valid", 32'(ex_valid), 32'(m.valid));
        check("ex_regwrite", 32'(ex_regwrite), 32'(m.regwrite));
        check("ex_memread", 32'(ex_memread), 32'(m.memread));
        check("ex_memwrite", 32'(ex_memwrite), 32'(m.memwrite));
        check("alu_fun", 32'(alu_fun), 32'(m.fun));
        check("alu_sign", 32'(alu_sign), 32'(m.sign));
        if (m.valid) begin
            check("alu_a", alu_a, m.src1 ? {27'd0, m.shamt} : exp_fwd(m.rs, m.rs_data));
            check("alu_b", alu_b, m.src2 ? m.imm : exp_fwd(m.rt, m.rt_data));
            check("store_data", ex_store_data, exp_fwd(m.rt, m.rt_data));
            check("ex_rd", 32'(ex_rd), 32'(m.rd));
        end
    endtask

    initial begin
        m = '0;
        reset = 0;
        rand_inputs();
        tick();
        tick();
        #1;
        check("rst_valid", 32'(ex_valid), 0);
        check("rst_regwrite", 32'(ex_regwrite), 0);
        check("rst_memrw", 32'({ex_memread, ex_memwrite}), 0);
        check("rst_fun", 32'(alu_fun), 0);
        check("rst_sign", 32'(alu_sign), 0);
        check("rst_rd", 32'(ex_rd), 0);
        @(negedge clk);
        reset = 1;
        idle();
        // ADD r3,r1,r2
        id_valid = 1; id_rs_addr = 1; id_rt_addr = 2; id_rd_addr = 3;
        id_rs_data = 5; id_rt_data = 7; id_alufun = ALU_ADD; id_regwrite = 1;
        #1 check("add_nostall", 32'(ld_stall), 0);
        tick(); idle(); #1;
        check("add_a", alu_a, 5);
        check("add_b", alu_b, 7);
        check("add_fun", 32'(alu_fun), 32'(ALU_ADD));
        check("add_valid", 32'(ex_valid), 1);
`ifdef FORWARDING_EN
        id_valid = 1; id_rs_addr = 1; id_rd_addr = 9; id_rs_data = 'h99; id_regwrite = 1;
        tick(); idle();
        exmem_regwrite = 1; exmem_rd = 1; exmem_result = 'h11;
        memwb_regwrite = 1; memwb_rd = 1; memwb_result = 'h22;
        #1 check("fwd_exmem_prio", alu_a, 'h11);
        exmem_regwrite = 0;
        #1 check("fwd_memwb", alu_a, 'h22);
        memwb_regwrite = 0;
        #1 check("fwd_none", alu_a, 'h99);
`endif
        idle();
        id_valid = 1; id_rs_addr = 0; id_rs_data = 0; id_rd_addr = 1;
        tick(); idle();
        exmem_regwrite = 1; exmem_rd = 0; exmem_result = 'h55;
        memwb_regwrite = 1; memwb_rd = 0; memwb_result = 'h66;
        #1 check("r0_no_fwd", alu_a, 0);
        idle();
`ifdef FORWARDING_EN
        // LW r4 then ADD r5,r4,r4
        id_valid = 1; id_rd_addr = 4; id_memread = 1; id_regwrite = 1; id_alusrc2 = 1; id_imm32 = 8;
        tick(); idle();
        id_valid = 1; id_rs_addr = 4; id_rt_addr = 4; id_rd_addr = 5; id_regwrite = 1;
        #1 check("lu_stall", 32'(ld_stall), 1);
        tick();
        exmem_regwrite = 1; exmem_rd = 4; exmem_result = 'h100;
        #1;
        check("lu_bubble", 32'(ex_valid), 0);
        check("lu_release", 32'(ld_stall), 0);
        tick();
        id_valid = 0; exmem_regwrite = 0;
        memwb_regwrite = 1; memwb_rd = 4; memwb_result = 'h1234;
        #1;
        check("lu_valid", 32'(ex_valid), 1);
        check("lu_a", alu_a, 'h1234);
        check("lu_b", alu_b, 'h1234);
        idle();
        // SW with rt forwarded from EX/MEM
        id_valid = 1; id_rs_addr = 1; id_rt_addr = 8; id_memwrite = 1; id_alusrc2 = 1; id_imm32 = 4;
        tick(); idle();
        exmem_regwrite = 1; exmem_rd = 8; exmem_result = 'hDEAD;
        #1;
        check("sw_store", ex_store_data, 'hDEAD);
        check("sw_b", alu_b, 4);
        idle();
`else
        // ADD r4 then dependent ADD: two bubbles, then register-file value
        id_valid = 1; id_rd_addr = 4; id_regwrite = 1;
        tick(); idle();
        id_valid = 1; id_rs_addr = 4; id_rd_addr = 5; id_regwrite = 1; id_rs_data = 0;
        #1 check("raw_stall1", 32'(ld_stall), 1);
        tick();
        exmem_regwrite = 1; exmem_rd = 4; exmem_result = 'h4444;
        #1 check("raw_stall2", 32'(ld_stall), 1);
        tick();
        exmem_regwrite = 0; memwb_regwrite = 1; memwb_rd = 4; memwb_result = 'h4444; id_rs_data = 'h4444;
        #1 check("raw_release", 32'(ld_stall), 0);
        tick(); idle(); #1;
        check("raw_valid", 32'(ex_valid), 1);
        check("raw_a", alu_a, 'h4444);
`endif
        // flush leaves alu_sign from the previous instruction
        id_valid = 1; id_sign = 1; id_rd_addr = 2; id_regwrite = 1;
        tick(); idle();
        id_valid = 1; id_sign = 0; id_rd_addr = 3; id_regwrite = 1; flush = 1;
        tick(); idle(); #1;
        check("flush_valid", 32'(ex_valid), 0);
        check("flush_regwrite", 32'(ex_regwrite), 0);
        check("flush_sign", 32'(alu_sign), 1);
        // SLL with shamt 3
        id_valid = 1; id_rt_addr = 6; id_rd_addr = 7; id_shamt = 3; id_alusrc1 = 1;
        id_alufun = ALU_SLL; id_rt_data = 'h40; id_regwrite = 1;
        tick(); idle(); #1;
        check("sll_a", alu_a, 3);
        check("sll_b", alu_b, 'h40);
        check("sll_fun", 32'(alu_fun), 32'(ALU_SLL));
        // reset in the middle of a load-use stall
        id_valid = 1; id_rd_addr = 4; id_memread = 1; id_regwrite = 1;
        tick(); idle();
        id_valid = 1; id_rs_addr = 4; id_rd_addr = 5;
        #1 check("mid_stall", 32'(ld_stall), 1);
        reset = 0;
        #1;
        check("mid_rst_valid", 32'(ex_valid), 0);
        check("mid_rst_stall", 32'(ld_stall), 0);
        m = '0;
        tick();
        reset = 1;
        idle();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            #1 compare_all();
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
